// File: rtl/sipo_rx_ctrl.sv
// Sequencer for an external WIDTH-bit serial-in/parallel-out shift register:
// frame clear, per-strobe shift gating, bit counting, word capture with valid/ready.
// Optional parity check over the frame is enabled by defining SIPO_PARITY_EN.
module sipo_rx_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             bit_valid,
    output logic             shift_en,
    output logic             sipo_clr,
    input  logic [WIDTH-1:0] sipo_q,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overrun,
`ifdef SIPO_PARITY_EN
    input  logic             parity_odd,
    input  logic             si,
    output logic             parity_err,
`endif
    output logic [CNT_W-1:0] bit_cnt
);

`ifdef SIPO_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, CAPTURE, PARITY} state_t;
    logic si_latched;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, CAPTURE} state_t;
`endif

    state_t state;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    // Shift-register controls are combinational so the shift lands on the same
    // edge the strobe is seen; abort and reset suppress both.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        shift_en = 1'b0;
        sipo_clr = 1'b0;
        if (!reset) begin
            shift_en = (state == SHIFT) && bit_valid && !abort;
            sipo_clr = (state == IDLE) && start && !abort;
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
`ifdef SIPO_PARITY_EN
            parity_err <= 1'b0;
            si_latched <= 1'b0;
`endif
        end else begin
            overrun <= 1'b0;
            if (out_valid && out_ready)
                out_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state   <= SHIFT;
                        bit_cnt <= '0;
                    end
                end

                SHIFT: begin
                    if (abort) begin
                        state   <= IDLE;
                        bit_cnt <= '0;
                    end else if (bit_valid) begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        if (bit_cnt == LAST_BIT)
`ifdef SIPO_PARITY_EN
                            state <= PARITY;
`else
                            state <= CAPTURE;
`endif
                    end
                end

`ifdef SIPO_PARITY_EN
                PARITY: begin
                    if (abort) begin
                        state   <= IDLE;
                        bit_cnt <= '0;
                    end else if (bit_valid) begin
                        si_latched <= si;
                        state      <= CAPTURE;
                    end
                end
`endif

                CAPTURE: begin
                    if (abort) begin
                        state   <= IDLE;
                        bit_cnt <= '0;
                    end else begin
                        // A capture in the same cycle as a handshake overrides the drop of out_valid.
                        if (!out_valid || out_ready) begin
                            data_out  <= sipo_q;
                            out_valid <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
`ifdef SIPO_PARITY_EN
                        parity_err <= ((^sipo_q) ^ si_latched) != parity_odd;
`endif
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sipo_rx_ctrl.sv
// Directed bench for sipo_rx_ctrl with a behavioural model of the external shift register.
// Covers reset, streaming and gapped frames, overrun, abort, and (with SIPO_PARITY_EN) parity.
module tb_sipo_rx_ctrl;

    localparam int W = 8;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          bit_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          ser_bit = 1'b0;
    logic          shift_en, sipo_clr, out_valid, busy, overrun;
    logic [W-1:0]  sr = '0;
    logic [W-1:0]  data_out;
    logic [CW-1:0] bit_cnt;
`ifdef SIPO_PARITY_EN
    logic          parity_odd = 1'b1;
    logic          si = 1'b0;
    logic          parity_err;
    logic          par_flip = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int shift_total = 0;

    sipo_rx_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .bit_valid (bit_valid),
        .shift_en  (shift_en),
        .sipo_clr  (sipo_clr),
        .sipo_q    (sr),
        .data_out  (data_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .overrun   (overrun),
`ifdef SIPO_PARITY_EN
        .parity_odd(parity_odd),
        .si        (si),
        .parity_err(parity_err),
`endif
        .bit_cnt   (bit_cnt)
    );

    always #5 clk = ~clk;

    // External shift register: shifts toward MSB, so the first bit ends in bit W-1.
    always @(posedge clk) begin
        if (sipo_clr) sr <= '0;
        else if (shift_en) sr <= {sr[W-2:0], ser_bit};
    end

    always @(posedge clk) if (shift_en) shift_total++;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_bits(input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) begin
            ser_bit = w[i];
            bit_valid = 1'b1;
            cyc();
        end
        bit_valid = 1'b0;
`ifdef SIPO_PARITY_EN
        si = ~(^w) ^ par_flip;
        bit_valid = 1'b1;
        cyc();
        bit_valid = 1'b0;
`endif
    endtask

    task automatic run_frame(input logic [W-1:0] w, input logic rdy);
        out_ready = rdy;
        start = 1'b1;
        cyc();
        start = 1'b0;
        shift_bits(w);
    endtask

    task automatic test_reset_init();
        reset = 1'b1;
        cyc();
        cyc();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL init_busy got %b exp 0", busy); end
        checks++; if (bit_cnt !== 5'd0) begin errors++; $display("FAIL init_bit_cnt got %0d exp 0", bit_cnt); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL init_out_valid got %b exp 0", out_valid); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL init_data_out got %h exp 00", data_out); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL init_overrun got %b exp 0", overrun); end
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_basic();
        int base;
        base = shift_total;
        run_frame(8'hB2, 1'b1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_capture got %b exp 1", busy); end
        checks++; if (bit_cnt !== 5'd8) begin errors++; $display("FAIL basic_bit_cnt got %0d exp 8", bit_cnt); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_early got %b exp 0", out_valid); end
        cyc();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid got %b exp 1", out_valid); end
        checks++; if (data_out !== 8'hB2) begin errors++; $display("FAIL basic_data got %h exp b2", data_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_idle got %b exp 0", busy); end
        checks++; if (bit_cnt !== 5'd8) begin errors++; $display("FAIL basic_cnt_held got %0d exp 8", bit_cnt); end
        checks++; if (shift_total - base !== 8) begin errors++; $display("FAIL basic_shift_cycles got %0d exp 8", shift_total - base); end
        cyc();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_fall got %b exp 0", out_valid); end
    endtask

    task automatic test_gapped();
        logic [W-1:0]  w;
        logic [CW-1:0] exp_cnt;
        int base;
        w = 8'hB2;
        out_ready = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        base = shift_total;
        for (int i = 0; i < W; i++) begin
            ser_bit = w[W-1-i];
            bit_valid = 1'b0;
            repeat (2) begin
                @(negedge clk);
                checks++; if (shift_en !== 1'b0) begin errors++; $display("FAIL gap_shift_en bit %0d got %b exp 0", i, shift_en); end
                cyc();
            end
            exp_cnt = CW'(i);
            checks++; if (bit_cnt !== exp_cnt) begin errors++; $display("FAIL gap_cnt_hold bit %0d got %0d exp %0d", i, bit_cnt, exp_cnt); end
            bit_valid = 1'b1;
            @(negedge clk);
            checks++; if (shift_en !== 1'b1) begin errors++; $display("FAIL gap_strobe bit %0d got %b exp 1", i, shift_en); end
            cyc();
            bit_valid = 1'b0;
            exp_cnt = CW'(i + 1);
            checks++; if (bit_cnt !== exp_cnt) begin errors++; $display("FAIL gap_cnt_inc bit %0d got %0d exp %0d", i, bit_cnt, exp_cnt); end
        end
`ifdef SIPO_PARITY_EN
        si = ~(^w);
        bit_valid = 1'b1;
        cyc();
        bit_valid = 1'b0;
`endif
        cyc();
        checks++; if (data_out !== 8'hB2) begin errors++; $display("FAIL gap_data got %h exp b2", data_out); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL gap_valid got %b exp 1", out_valid); end
        checks++; if (shift_total - base !== 8) begin errors++; $display("FAIL gap_shift_cycles got %0d exp 8", shift_total - base); end
        cyc();
    endtask

    task automatic test_overrun();
        run_frame(8'hB2, 1'b0);
        cyc();
        checks++; if (out_valid !== 1'b1 || data_out !== 8'hB2) begin errors++; $display("FAIL ovr_first got v=%b d=%h exp v=1 d=b2", out_valid, data_out); end
        run_frame(8'h4D, 1'b0);
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_early got %b exp 0", overrun); end
        cyc();
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_pulse got %b exp 1", overrun); end
        checks++; if (data_out !== 8'hB2) begin errors++; $display("FAIL ovr_data_held got %h exp b2", data_out); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid_held got %b exp 1", out_valid); end
        cyc();
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_one_cycle got %b exp 0", overrun); end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid_before_ack got %b exp 1", out_valid); end
        cyc();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovr_valid_fall got %b exp 0", out_valid); end
        checks++; if (data_out !== 8'hB2) begin errors++; $display("FAIL ovr_data_after got %h exp b2", data_out); end
    endtask

    task automatic test_abort();
        logic [4:0] pre;
        pre = 5'b10101;
        out_ready = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 4; i >= 3; i--) begin ser_bit = pre[i]; bit_valid = 1'b1; cyc(); end
        bit_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        checks++; if (sipo_clr !== 1'b0) begin errors++; $display("FAIL busy_start_clr got %b exp 0", sipo_clr); end
        cyc();
        start = 1'b0;
        checks++; if (bit_cnt !== 5'd2 || busy !== 1'b1) begin errors++; $display("FAIL busy_start_ignored got cnt=%0d busy=%b exp cnt=2 busy=1", bit_cnt, busy); end
        for (int i = 2; i >= 0; i--) begin ser_bit = pre[i]; bit_valid = 1'b1; cyc(); end
        checks++; if (bit_cnt !== 5'd5) begin errors++; $display("FAIL abort_pre_cnt got %0d exp 5", bit_cnt); end
        abort = 1'b1;
        bit_valid = 1'b1;
        ser_bit = 1'b1;
        @(negedge clk);
        checks++; if (shift_en !== 1'b0) begin errors++; $display("FAIL abort_shift_en got %b exp 0", shift_en); end
        cyc();
        abort = 1'b0;
        bit_valid = 1'b0;
        checks++; if (busy !== 1'b0 || bit_cnt !== 5'd0) begin errors++; $display("FAIL abort_idle got busy=%b cnt=%0d exp busy=0 cnt=0", busy, bit_cnt); end
        repeat (3) cyc();
        checks++; if (out_valid !== 1'b0 || data_out !== 8'hB2) begin errors++; $display("FAIL abort_no_capture got v=%b d=%h exp v=0 d=b2", out_valid, data_out); end
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        checks++; if (sipo_clr !== 1'b0) begin errors++; $display("FAIL abort_start_clr got %b exp 0", sipo_clr); end
        cyc();
        abort = 1'b0;
        start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_start_busy got %b exp 0", busy); end
        start = 1'b1;
        @(negedge clk);
        checks++; if (sipo_clr !== 1'b1) begin errors++; $display("FAIL start_clr got %b exp 1", sipo_clr); end
        cyc();
        start = 1'b0;
        checks++; if (sr !== 8'h00) begin errors++; $display("FAIL start_sr_cleared got %h exp 00", sr); end
        shift_bits(8'hFF);
        cyc();
        checks++; if (data_out !== 8'hFF || out_valid !== 1'b1) begin errors++; $display("FAIL abort_next_frame got v=%b d=%h exp v=1 d=ff", out_valid, data_out); end
        cyc();
    endtask

    task automatic test_reset_mid_frame();
        run_frame(8'h5A, 1'b0);
        cyc();
        checks++; if (out_valid !== 1'b1 || data_out !== 8'h5A) begin errors++; $display("FAIL rst_pending got v=%b d=%h exp v=1 d=5a", out_valid, data_out); end
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin ser_bit = 1'b1; bit_valid = 1'b1; cyc(); end
        checks++; if (bit_cnt !== 5'd3) begin errors++; $display("FAIL rst_pre_cnt got %0d exp 3", bit_cnt); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (shift_en !== 1'b0) begin errors++; $display("FAIL rst_shift_en got %b exp 0", shift_en); end
        cyc();
        start = 1'b1;
        @(negedge clk);
        checks++; if (sipo_clr !== 1'b0) begin errors++; $display("FAIL rst_sipo_clr got %b exp 0", sipo_clr); end
        cyc();
        reset = 1'b0;
        start = 1'b0;
        bit_valid = 1'b0;
        checks++; if (busy !== 1'b0 || bit_cnt !== 5'd0) begin errors++; $display("FAIL rst_state got busy=%b cnt=%0d exp busy=0 cnt=0", busy, bit_cnt); end
        checks++; if (out_valid !== 1'b0 || data_out !== 8'h00) begin errors++; $display("FAIL rst_output got v=%b d=%h exp v=0 d=00", out_valid, data_out); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun got %b exp 0", overrun); end
    endtask

`ifdef SIPO_PARITY_EN
    task automatic test_parity();
        parity_odd = 1'b1;
        par_flip = 1'b0;
        run_frame(8'hB2, 1'b1);
        cyc();
        checks++; if (parity_err !== 1'b0 || data_out !== 8'hB2) begin errors++; $display("FAIL par_good got err=%b d=%h exp err=0 d=b2", parity_err, data_out); end
        cyc();
        par_flip = 1'b1;
        run_frame(8'hB2, 1'b1);
        cyc();
        checks++; if (parity_err !== 1'b1 || data_out !== 8'hB2) begin errors++; $display("FAIL par_bad got err=%b d=%h exp err=1 d=b2", parity_err, data_out); end
        par_flip = 1'b0;
        cyc();
    endtask
`endif

    initial begin
        test_reset_init();
        test_basic();
        test_gapped();
        test_overrun();
        test_abort();
`ifdef SIPO_PARITY_EN
        test_parity();
`endif
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
